// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_types_pkg
//  Brief    : Shared CPU types for the instruction cache. Holds the fetch
//             address split, the cache frame record and the icache states.
//  Revision : 1.0  initial release
// ============================================================================
package cpu_types_pkg;

  // Address field widths for the default 16-frame, one-word-per-frame icache.
  localparam int ITAG_W = 26;
  localparam int IIDX_W = 4;
  localparam int IBYT_W = 2;

  // Fetch address viewed as tag / index / byte offset.
  typedef struct packed {
    logic [ITAG_W-1:0] tag;
    logic [IIDX_W-1:0] idx;
    logic [IBYT_W-1:0] bytoff;
  } icachef_t;

  // One direct-mapped frame: valid bit, tag and a single instruction word.
  typedef struct packed {
    logic              valid;
    logic [ITAG_W-1:0] tag;
    logic [31:0]       data;
  } icache_frame_t;

  // Two-state controller: look up in IDLE, wait on memory in MISS.
  typedef enum logic [0:0] {
    IC_IDLE = 1'b0,
    IC_MISS = 1'b1
  } icache_state_e;

endpackage : cpu_types_pkg
`default_nettype wire

// File: rtl/icache.sv
`default_nettype none
// ============================================================================
//  Module   : icache
//  Brief    : Direct-mapped, one-word-per-frame, read-only instruction cache.
//             Zero-cycle hits in IDLE; a miss moves to MISS and requests the
//             live fetch address from memory until the word arrives.
//  Revision : 1.0  initial release
// ============================================================================
module icache
  import cpu_types_pkg::*;
#(
  parameter int FRAMES = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  // datapath side
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  // memory side
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  localparam int IDX_W = $clog2(FRAMES);
  localparam int TAG_W = 32 - IDX_W - IBYT_W;

  icache_state_e     state_q, state_d;
  logic [FRAMES-1:0] valid_q;
  logic [TAG_W-1:0]  tag_q  [FRAMES];
  logic [31:0]       data_q [FRAMES];

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              hit;
  logic              fill_en;

  // Lookup, next-state and output decode; all outputs derive from the live
  // fetch address so a redirect during MISS is followed immediately.
  always_comb begin
    idx      = imemaddr[IDX_W+IBYT_W-1:IBYT_W];
    tag      = imemaddr[31:IDX_W+IBYT_W];
    hit      = imemREN & valid_q[idx] & (tag_q[idx] == tag);
    state_d  = state_q;
    fill_en  = 1'b0;
    ihit     = 1'b0;
    imemload = '0;
    iREN     = 1'b0;
    iaddr    = '0;
    case (state_q)
      IC_IDLE: begin
        // Word is gated by hit so imemload reads zero on any non-hit cycle.
        ihit     = hit;
        imemload = hit ? data_q[idx] : 32'h0;
        if (imemREN && !hit) begin
          state_d = IC_MISS;
        end
      end
      IC_MISS: begin
        iREN  = imemREN;
        iaddr = imemaddr & 32'hFFFF_FFFC;
        if (!imemREN) begin
          // Fetch squashed by the datapath: abandon without writing.
          state_d = IC_IDLE;
        end else if (!iwait) begin
          fill_en = 1'b1;
          state_d = IC_IDLE;
        end
      end
      default: begin
        state_d = IC_IDLE;
      end
    endcase
  end

  // State and frame storage; only valid bits need clearing on reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IC_IDLE;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      if (fill_en) begin
        valid_q[idx] <= 1'b1;
        tag_q[idx]   <= tag;
        data_q[idx]  <= iload;
      end
    end
  end

endmodule : icache
`default_nettype wire
